// File: rtl/mult_shift_add_unit_pkg.sv
// Shared types and sizing for the shift-add multiplier.
// State encoding is fixed so HI/LO-side debug taps can decode it directly.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH) + 1;

endpackage

// File: rtl/mult_shift_add_unit_if.sv
// Request/result bundle between the MULT/MULTU issue logic and the multiplier.
interface mult_shift_add_unit_if #(
  parameter int WIDTH = 32
);

  logic                 Start;
  logic                 Signed;
  logic [WIDTH-1:0]     Multiplicand;
  logic [WIDTH-1:0]     Multiplier;
  logic [2*WIDTH-1:0]   Product;
  logic                 Busy;
  logic                 Done;

  modport master (
    output Start,
    output Signed,
    output Multiplicand,
    output Multiplier,
    input  Product,
    input  Busy,
    input  Done
  );

  modport slave (
    input  Start,
    input  Signed,
    input  Multiplicand,
    input  Multiplier,
    output Product,
    output Busy,
    output Done
  );

endinterface

// File: rtl/mult_shift_add_unit_iter_counter.sv
// Iteration counter for the shift-add loop; Last flags the final step.
// Clear wins over Enable so a new operation always restarts from zero.
module mult_iter_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  input  logic Enable,
  output logic Last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (Clear) begin
      count <= '0;
    end else if (Enable) begin
      count <= count + 1'b1;
    end
  end

  assign Last = (count == LAST_CNT);

endmodule

// File: rtl/mult_shift_add_unit.sv
// Sequential shift-add multiplier for MULT/MULTU: one add/shift per clock,
// magnitudes multiplied unsigned and the sign reapplied on the final step.
module mult_shift_add_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      Clk,
  input  logic                      Reset,
  mult_shift_add_unit_if.slave      bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t state, state_nxt;

  logic accept;
  logic step;
  logic last;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mreg;
  logic               neg_flag;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   mreg_nxt;
  logic [2*WIDTH-1:0] full_nxt;

  // |most-negative| equals 2^(WIDTH-1), which still fits as an unsigned magnitude
  always_comb begin
    a_mag = bus.Multiplicand;
    b_mag = bus.Multiplier;
    if (bus.Signed && bus.Multiplicand[WIDTH-1]) begin
      a_mag = -bus.Multiplicand;
    end
    if (bus.Signed && bus.Multiplier[WIDTH-1]) begin
      b_mag = -bus.Multiplier;
    end
  end

  // Adder carry lands in acc's MSB after the shift, so nothing is lost
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, mcand};
    acc_nxt  = {1'b0, acc[WIDTH-1:1]};
    mreg_nxt = {acc[0], mreg[WIDTH-1:1]};
    if (mreg[0]) begin
      acc_nxt  = sum[WIDTH:1];
      mreg_nxt = {sum[0], mreg[WIDTH-1:1]};
    end
    full_nxt = {acc_nxt, mreg_nxt};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    bus.Busy  = 1'b0;
    bus.Done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        step     = 1'b1;
        bus.Busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.Done = 1'b1;
        if (bus.Start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mcand    <= '0;
      acc      <= '0;
      mreg     <= '0;
      neg_flag <= 1'b0;
    end else if (accept) begin
      mcand    <= a_mag;
      mreg     <= b_mag;
      acc      <= '0;
      neg_flag <= bus.Signed & (bus.Multiplicand[WIDTH-1] ^ bus.Multiplier[WIDTH-1]);
    end else if (step) begin
      acc  <= acc_nxt;
      mreg <= mreg_nxt;
    end
  end

  // Product only changes on the last step, so it holds across later CALC phases
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      product_q <= '0;
    end else if (step && last) begin
      product_q <= neg_flag ? -full_nxt : full_nxt;
    end
  end

  assign bus.Product = product_q;

  mult_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CW)
  ) u_iter_counter (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clear  (accept),
    .Enable (step),
    .Last   (last)
  );

endmodule

// File: tb/tb_mult_shift_add_unit.sv
// Self-checking bench for mult_shift_add_unit: directed and random operations
// compared against a plain-arithmetic reference product.
module tb_mult_shift_add_unit;

  localparam int W = 32;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  mult_shift_add_unit_if #(.WIDTH(W)) bus ();

  mult_shift_add_unit #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [63:0] prev_prod = 64'h0;

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge: presents Start for one edge then scrambles the operands
  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
    bus.Start        = 1'b1;
    bus.Signed       = s;
    bus.Multiplicand = a;
    bus.Multiplier   = b;
    @(negedge Clk);
    bus.Start        = 1'b0;
    bus.Signed       = 1'($urandom_range(0, 1));
    bus.Multiplicand = $urandom;
    bus.Multiplier   = $urandom;
  endtask

  // Returns at the negedge where Done is high; inject_at >= 0 re-pulses Start mid-CALC
  task automatic wait_done(input string tag, input logic [63:0] exp, input int inject_at);
    int n = 0;
    bit busy_ok = 1'b1;
    bit hold_ok = 1'b1;
    while (bus.Done !== 1'b1 && n < 40) begin
      if (bus.Busy !== 1'b1) busy_ok = 1'b0;
      if (bus.Product !== prev_prod) hold_ok = 1'b0;
      if (n == inject_at) begin
        bus.Start        = 1'b1;
        bus.Signed       = 1'b0;
        bus.Multiplicand = 32'd2;
        bus.Multiplier   = 32'd2;
      end else begin
        bus.Start = 1'b0;
      end
      @(negedge Clk);
      n++;
    end
    bus.Start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'(W));
    chk({tag, " busy"}, 64'(busy_ok), 64'd1);
    chk({tag, " hold"}, 64'(hold_ok), 64'd1);
    chk({tag, " product"}, bus.Product, exp);
    chk({tag, " busy_in_done"}, 64'(bus.Busy), 64'd0);
    prev_prod = exp;
  endtask

  task automatic pulse_end(input string tag);
    @(negedge Clk);
    chk({tag, " done_pulse"}, 64'(bus.Done), 64'd0);
  endtask

  initial begin
    bit          stable;
    bit          s;
    logic [31:0] a;
    logic [31:0] b;

    bus.Start        = 1'b0;
    bus.Signed       = 1'b0;
    bus.Multiplicand = '0;
    bus.Multiplier   = '0;

    #12;
    chk("rst busy", 64'(bus.Busy), 64'd0);
    chk("rst done", 64'(bus.Done), 64'd0);
    chk("rst product", bus.Product, 64'd0);
    @(negedge Clk);
    Reset = 1'b0;

    @(negedge Clk);
    issue(1'b0, 32'd3, 32'd5);
    wait_done("u3x5", 64'h0000_0000_0000_000F, -1);
    pulse_end("u3x5");

    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("uffxff", 64'hFFFF_FFFE_0000_0001, -1);
    pulse_end("uffxff");

    issue(1'b1, 32'hFFFF_FFFD, 32'd5);
    wait_done("s-3x5", 64'hFFFF_FFFF_FFFF_FFF1, -1);
    pulse_end("s-3x5");

    issue(1'b1, 32'h8000_0000, 32'h8000_0000);
    wait_done("sminxmin", 64'h4000_0000_0000_0000, -1);
    pulse_end("sminxmin");

    issue(1'b1, 32'd7, 32'hFFFF_FFFF);
    wait_done("s7x-1", 64'hFFFF_FFFF_FFFF_FFF9, -1);
    pulse_end("s7x-1");

    // Start during CALC ignored, then back-to-back Start in the DONE cycle
    issue(1'b0, 32'h0000_1234, 32'h0000_0010);
    wait_done("ignore", 64'h0000_0000_0001_2340, 9);
    issue(1'b0, 32'd6, 32'd7);
    wait_done("b2b", 64'd42, -1);
    pulse_end("b2b");

    stable = 1'b1;
    repeat (50) begin
      @(negedge Clk);
      if (bus.Product !== prev_prod || bus.Done !== 1'b0) stable = 1'b0;
    end
    chk("idle hold", 64'(stable), 64'd1);

    // Asynchronous reset in the middle of CALC
    issue(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    repeat (14) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("arst busy", 64'(bus.Busy), 64'd0);
    chk("arst done", 64'(bus.Done), 64'd0);
    chk("arst product", bus.Product, 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    prev_prod = 64'h0;
    stable = 1'b1;
    repeat (40) begin
      @(negedge Clk);
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.Product !== 64'h0) stable = 1'b0;
    end
    chk("arst no_done", 64'(stable), 64'd1);

    issue(1'b0, 32'd1000, 32'd1000);
    wait_done("post_rst", 64'd1000000, -1);
    pulse_end("post_rst");

    for (int i = 0; i < 6; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      issue(s, a, b);
      wait_done($sformatf("rand%0d", i), model(s, a, b), -1);
      pulse_end($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_shift_add_unit.md
Name: mult_shift_add_unit

Overview:
Sequential shift-add 32x32 multiplier datapath plus control for the CPU's MULT/MULTU path. It accepts operands on a Start handshake and runs one add/shift step per clock. When the iteration count reaches WIDTH it raises a one-cycle Done with the full 2*WIDTH product, which the HI/LO register stage consumes. It replaces the free-running load/terminal-count pairing with an internal, width-parameterised iteration counter and explicit Busy/Done signalling.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH; iteration counter width = clog2(WIDTH)+1

Ports:
Clk  input  1  rising-edge clock (single clock domain)
Reset  input  1  asynchronous, active-high reset
Start  input  1  request; sampled on rising Clk, accepted only while Busy=0
Signed  input  1  1=MULT (two's complement), 0=MULTU; sampled with Start
Multiplicand  input  WIDTH  operand A; sampled with Start
Multiplier  input  WIDTH  operand B; sampled with Start
Product  output  2*WIDTH  result; valid from the Done cycle, held until the next accepted Start
Busy  output  1  high from the cycle after acceptance through the last add/shift cycle
Done  output  1  one-cycle pulse, result valid

Behaviour:
- Reset (async, any state): state=IDLE, Product=0, Busy=0, Done=0, accumulator/shift regs=0, iteration count=0. Reset mid-operation discards the operation with no Done.
- States: IDLE, CALC, DONE.
- IDLE: Start=1 at edge -> latch |A|,|B| (unsigned if Signed=0), neg_flag = Signed & (A[W-1]^B[W-1]), acc=0, count=0 -> CALC.
- CALC: per edge, if mreg[0] then {acc,mreg} = ({carry,acc+mcand} , mreg)>>1, else {acc,mreg}>>1. Addition uses a WIDTH+1-bit sum; the carry is never dropped. count increments. After WIDTH steps (count==WIDTH-1 at edge) -> DONE.
- Start during CALC is ignored with no side effect.
- DONE (one cycle): Product = neg_flag ? -{acc,mreg} : {acc,mreg}. The Product register loads on the CALC->DONE edge, so it is visible while Done=1. Done=1, Busy=0. Next edge -> IDLE; if Start=1 in DONE it is accepted exactly as in IDLE (back-to-back ops).
- Latency: Start sampled at edge k -> Busy=1 after edges k..k+WIDTH-1 -> Done=1 after edge k+WIDTH (WIDTH+1 cycles Start-to-Done).
- Signed magnitude: |0x80000000| = 0x80000000 fits WIDTH unsigned bits, so no overflow special case is needed. Negation is 2*WIDTH two's complement.
- Zero operands take the full WIDTH cycles; no early termination.
- Product is not cleared by Start; it holds its old value until the DONE edge.

Decomposition:
- Package mult_pkg: state enum (IDLE=2'd0, CALC=2'd1, DONE=2'd2), default WIDTH, localparam CNT_W=clog2(WIDTH)+1.
- One sub-module, mult_iter_counter:
  - inputs Clk, Reset, Clear, Enable; output Last.
  - Last asserts when count==WIDTH-1.
  - Clear has priority over Enable.
  - It is the parameterised successor of the terminal-count counter.
- Datapath (abs, adder, shift, final negate) and FSM stay in the top.

Test Plan:
- Unsigned 3 x 5, Start at cycle 0 -> Busy high cycles 1..32, Done pulse at cycle 33, Product=0x000000000000000F.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> Product=0xFFFFFFFE00000001 (carry path exercised).
- Signed -3 (0xFFFFFFFD) x 5 -> Product=0xFFFFFFFFFFFFFFF1. Signed 0x80000000 x 0x80000000 -> 0x4000000000000000. Signed 7 x -1 -> 0xFFFFFFFFFFFFFFF9.
- Start re-pulsed with new operands (2x2) at cycle 10 during CALC -> ignored; Done at cycle 33 with the original result. Start held high in the DONE cycle with 6x7 -> accepted, second Done 33 cycles later, Product=42.
- Reset asserted asynchronously mid-CALC (cycle 15, between edges) -> Busy=0, Done=0, Product=0 immediately. No Done follows. A new op afterwards completes correctly.
- Product hold: after the Done pulse, Product stays at its value for 50 idle cycles and is unchanged during the next op's CALC until its Done.
